box_motion_ctrl: RTL and testbench

//   Per-frame controller for the on-screen box. Sits between the board buttons, the video timing

---
 rtl/box_pkg.sv | 31 +++
 rtl/box_motion_ctrl_debounce.sv | 38 +++
 rtl/box_motion_ctrl.sv | 149 ++++++++++++++
 tb/tb_box_motion_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/box_pkg.sv
// Shared constants, FSM encoding and clamp helper for the box motion controller.
package box_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_MOVE   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [7:0] RED_RST   = 8'd0;
    localparam logic [7:0] GREEN_RST = 8'd80;
    localparam logic [7:0] BLUE_RST  = 8'd160;

    // Saturating step in 11 bits: never below 0, never above lim.
    function automatic logic [10:0] step_clamp(input logic [10:0] pos, input logic dec,
                                               input logic [10:0] step, input logic [10:0] lim);
        logic [10:0] r;
        if (dec) begin
            r = (pos < step) ? 11'd0 : pos - step;
        end else begin
            r = pos + step;
            if (r > lim) r = lim;
        end
        return r;
    endfunction

endpackage

// File: rtl/box_motion_ctrl_debounce.sv
// Per-button synchroniser plus frame-rate debouncer; accepted level flips after
// DEB_FRAMES consecutive frame ticks with the synced level differing from it.
module btn_debounce #(
    parameter int DEB_FRAMES = 2
) (
    input  logic clk_25mhz,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level
);
    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic       level_q;

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b00;
            cnt_q   <= 4'd0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (tick) begin
                if (sync_q[1] == level_q) begin
                    cnt_q <= 4'd0;
                end else if (cnt_q == 4'(DEB_FRAMES - 1)) begin
                    level_q <= ~level_q;
                    cnt_q   <= 4'd0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/box_motion_ctrl.sv
// Per-frame box position/colour sequencer; outputs update 3 cycles after frame_tick.
// Optional AUTO_BOUNCE_EN macro adds per-axis bounce motion when no button is held.
module box_motion_ctrl
    import box_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int BOX_W      = 100,
    parameter int BOX_H      = 100,
    parameter int STEP       = 1,
    parameter int DEB_FRAMES = 2,
    parameter int INIT_X     = 40,
    parameter int INIT_Y     = 40
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       frame_tick
);
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_W);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_H);
    localparam logic [10:0] STEP_W = 11'(STEP);

    logic [1:0]  vs_sync_q;
    logic        vs_prev_q;
    logic        tick_q;
    logic        lvl_left, lvl_right, lvl_up, lvl_down;
    state_t      state_q;
    logic [3:0]  btn_q;
    logic [10:0] nx_q, ny_q, nx_d, ny_d;
    logic [9:0]  box_x_q, box_y_q;
    logic [7:0]  red_q, green_q, blue_q;
    logic        mv_x, dec_x, mv_y, dec_y;
`ifdef AUTO_BOUNCE_EN
    logic        dir_x_q, dir_y_q, dir_x_d, dir_y_d;
`endif

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            vs_sync_q <= 2'b00;
            vs_prev_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            vs_sync_q <= {vs_sync_q[0], vsync};
            vs_prev_q <= vs_sync_q[1];
            tick_q    <= vs_sync_q[1] & ~vs_prev_q;
        end
    end

    btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_left  (.clk_25mhz(clk_25mhz), .rst(rst), .tick(tick_q), .raw(btn_left),  .level(lvl_left));
    btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_right (.clk_25mhz(clk_25mhz), .rst(rst), .tick(tick_q), .raw(btn_right), .level(lvl_right));
    btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_up    (.clk_25mhz(clk_25mhz), .rst(rst), .tick(tick_q), .raw(btn_up),    .level(lvl_up));
    btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_down  (.clk_25mhz(clk_25mhz), .rst(rst), .tick(tick_q), .raw(btn_down),  .level(lvl_down));

    // btn_q = {left, right, up, down}; opposing buttons cancel on their axis.
    always_comb begin
        mv_x  = btn_q[3] ^ btn_q[2];
        dec_x = btn_q[3];
        mv_y  = btn_q[1] ^ btn_q[0];
        dec_y = btn_q[1];
`ifdef AUTO_BOUNCE_EN
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (mv_x) begin
            dir_x_d = btn_q[2];
        end else if (!btn_q[3]) begin
            mv_x  = 1'b1;
            dec_x = ~dir_x_q;
        end
        if (mv_y) begin
            dir_y_d = btn_q[0];
        end else if (!btn_q[1]) begin
            mv_y  = 1'b1;
            dec_y = ~dir_y_q;
        end
`endif
        nx_d = mv_x ? step_clamp({1'b0, box_x_q}, dec_x, STEP_W, X_MAX) : {1'b0, box_x_q};
        ny_d = mv_y ? step_clamp({1'b0, box_y_q}, dec_y, STEP_W, Y_MAX) : {1'b0, box_y_q};
`ifdef AUTO_BOUNCE_EN
        if (!(btn_q[3] | btn_q[2]) && (nx_d == (dec_x ? 11'd0 : X_MAX))) dir_x_d = ~dir_x_q;
        if (!(btn_q[1] | btn_q[0]) && (ny_d == (dec_y ? 11'd0 : Y_MAX))) dir_y_d = ~dir_y_q;
`endif
    end

    // The registered outputs land on the edge that enters COMMIT, 3 cycles after the tick.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            btn_q   <= 4'b0000;
            nx_q    <= 11'(INIT_X);
            ny_q    <= 11'(INIT_Y);
            box_x_q <= 10'(INIT_X);
            box_y_q <= 10'(INIT_Y);
            red_q   <= RED_RST;
            green_q <= GREEN_RST;
            blue_q  <= BLUE_RST;
`ifdef AUTO_BOUNCE_EN
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_q) begin
                        btn_q   <= {lvl_left, lvl_right, lvl_up, lvl_down};
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    nx_q    <= nx_d;
                    ny_q    <= ny_d;
`ifdef AUTO_BOUNCE_EN
                    dir_x_q <= dir_x_d;
                    dir_y_q <= dir_y_d;
`endif
                    state_q <= ST_MOVE;
                end
                ST_MOVE: begin
                    box_x_q <= nx_q[9:0];
                    box_y_q <= ny_q[9:0];
                    red_q   <= red_q + 8'd1;
                    green_q <= green_q + 8'd2;
                    blue_q  <= blue_q + 8'd1;
                    state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign box_x      = box_x_q;
    assign box_y      = box_y_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Directed frame-by-frame bench for box_motion_ctrl (debounce, clamp, colour, reset).
module tb_box_motion_ctrl;
    import box_pkg::*;

    logic       clk_25mhz = 1'b0;
    logic       rst, vsync;
    logic       btn_left, btn_right, btn_up, btn_down;
    logic [9:0] box_x, box_y;
    logic [7:0] red, green, blue;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;
    int n_commit = 0;
    int cur_x = 40;
    int cur_y = 40;

    typedef struct {
        logic [3:0] btn;   // {left, right, up, down}
        int         ex;
        int         ey;
    } vec_t;

    vec_t tbl[22];

    box_motion_ctrl dut (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .vsync     (vsync),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .box_x     (box_x),
        .box_y     (box_y),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .frame_tick(frame_tick)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] b, input int x, input int y);
        vec_t v;
        v.btn = b;
        v.ex  = x;
        v.ey  = y;
        return v;
    endfunction

    // One frame: apply buttons, pulse vsync, check hold then update 3 cycles after the tick.
    task automatic run_frame(input logic [3:0] b, input int ex, input int ey);
        int t;
        {btn_left, btn_right, btn_up, btn_down} = b;
        repeat (2) @(negedge clk_25mhz);
        vsync = 1'b1;
        t = 0;
        do begin
            @(negedge clk_25mhz);
            t++;
        end while (!frame_tick && t < 20);
        if (!frame_tick) check("tick_timeout", 0, 1);
        @(negedge clk_25mhz);
        check("tick_pulse", int'(frame_tick), 0);
        @(negedge clk_25mhz);
        check("hold_x", int'(box_x), cur_x);
        check("hold_y", int'(box_y), cur_y);
        @(negedge clk_25mhz);
        n_commit++;
        check("box_x", int'(box_x), ex);
        check("box_y", int'(box_y), ey);
        check("red", int'(red), n_commit % 256);
        check("green", int'(green), (80 + 2 * n_commit) % 256);
        check("blue", int'(blue), (160 + n_commit) % 256);
        cur_x = ex;
        cur_y = ey;
        vsync = 1'b0;
        repeat (8) @(negedge clk_25mhz);
    endtask

    initial begin
        int ex;
        int t;
`ifdef AUTO_BOUNCE_EN
        int mx, my;
        bit mdx, mdy;
`endif
        rst = 1'b1;
        vsync = 1'b0;
        {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
        repeat (3) @(negedge clk_25mhz);
        check("rst_x", int'(box_x), 40);
        check("rst_y", int'(box_y), 40);
        check("rst_red", int'(red), 0);
        check("rst_green", int'(green), 80);
        check("rst_blue", int'(blue), 160);
        check("rst_tick", int'(frame_tick), 0);
        check("rst_state", int'(dut.state_q), int'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk_25mhz);

`ifndef AUTO_BOUNCE_EN
        tbl[0]  = mk(4'b0100, 40, 40);
        tbl[1]  = mk(4'b0100, 40, 40);
        tbl[2]  = mk(4'b0100, 41, 40);
        tbl[3]  = mk(4'b0100, 42, 40);
        tbl[4]  = mk(4'b0100, 43, 40);
        tbl[5]  = mk(4'b1110, 44, 40);
        tbl[6]  = mk(4'b1110, 45, 40);
        tbl[7]  = mk(4'b1110, 45, 39);
        tbl[8]  = mk(4'b1110, 45, 38);
        tbl[9]  = mk(4'b0000, 45, 37);
        tbl[10] = mk(4'b0000, 45, 36);
        tbl[11] = mk(4'b0000, 45, 36);
        tbl[12] = mk(4'b0010, 45, 36);
        tbl[13] = mk(4'b0000, 45, 36);
        tbl[14] = mk(4'b0000, 45, 36);
        tbl[15] = mk(4'b0101, 45, 36);
        tbl[16] = mk(4'b0101, 45, 36);
        tbl[17] = mk(4'b0101, 46, 37);
        tbl[18] = mk(4'b0101, 47, 38);
        tbl[19] = mk(4'b0000, 48, 39);
        tbl[20] = mk(4'b0000, 49, 40);
        tbl[21] = mk(4'b0000, 49, 40);
        for (int i = 0; i < 22; i++) run_frame(tbl[i].btn, tbl[i].ex, tbl[i].ey);

        // Left into the 0 bound: saturates, never wraps.
        for (int k = 1; k <= 55; k++) begin
            ex = (k < 3) ? 49 : ((49 - (k - 2)) < 0 ? 0 : 49 - (k - 2));
            run_frame(4'b1000, ex, 40);
        end
        check("left_floor", int'(box_x), 0);

        // Right into the 540 bound.
        for (int k = 1; k <= 545; k++) begin
            ex = (k - 2) < 0 ? 0 : ((k - 2) > 540 ? 540 : k - 2);
            run_frame(4'b0100, ex, 40);
        end
        check("right_ceiling", int'(box_x), 540);

        // Reset asserted while the FSM sits in COMMIT.
        {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
        vsync = 1'b1;
        t = 0;
        do begin
            @(negedge clk_25mhz);
            t++;
        end while (!frame_tick && t < 20);
        if (!frame_tick) check("tick_timeout", 0, 1);
        repeat (3) @(negedge clk_25mhz);
        check("pre_rst_state", int'(dut.state_q), int'(ST_COMMIT));
        check("pre_rst_x", int'(box_x), 540);
        rst = 1'b1;
        @(negedge clk_25mhz);
        check("mid_rst_x", int'(box_x), 40);
        check("mid_rst_y", int'(box_y), 40);
        check("mid_rst_red", int'(red), 0);
        check("mid_rst_green", int'(green), 80);
        check("mid_rst_blue", int'(blue), 160);
        check("mid_rst_state", int'(dut.state_q), int'(ST_IDLE));
        vsync = 1'b0;
        @(negedge clk_25mhz);
        rst = 1'b0;
        repeat (4) @(negedge clk_25mhz);
        n_commit = 0;
        cur_x = 40;
        cur_y = 40;

        for (int k = 0; k < 128; k++) run_frame(4'b0000, 40, 40);
        check("green_128", int'(green), 80);
        check("red_128", int'(red), 128);
        check("blue_128", int'(blue), 32);
`else
        mx = 40;
        my = 40;
        mdx = 1'b1;
        mdy = 1'b1;
        for (int k = 1; k <= 505; k++) begin
            if (mdx) begin
                if (mx + 1 >= 540) begin mx = 540; mdx = 1'b0; end else mx = mx + 1;
            end else begin
                if (mx - 1 <= 0) begin mx = 0; mdx = 1'b1; end else mx = mx - 1;
            end
            if (mdy) begin
                if (my + 1 >= 380) begin my = 380; mdy = 1'b0; end else my = my + 1;
            end else begin
                if (my - 1 <= 0) begin my = 0; mdy = 1'b1; end else my = my - 1;
            end
            run_frame(4'b0000, mx, my);
            if (k == 498) check("bounce_538", int'(box_x), 538);
            if (k == 499) check("bounce_539", int'(box_x), 539);
            if (k == 500) check("bounce_540", int'(box_x), 540);
            if (k == 501) check("bounce_back_539", int'(box_x), 539);
            if (k == 502) check("bounce_back_538", int'(box_x), 538);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
